// File: rtl/pc_region_profiler_if.sv
// Signal bundle of pc_region_profiler: pipeline observation, region configuration and read port.
interface pc_region_profiler_if #(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PASS_W      = 16
);
    localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic                   pc_valid_i;
    logic [PC_W-1:0]        pc_i;
    logic                   retire_i;
    logic                   cfg_we_i;
    logic [IDX_W-1:0]       cfg_idx_i;
    logic [PC_W-1:0]        cfg_start_pc_i;
    logic [PC_W-1:0]        cfg_end_pc_i;
    logic                   cfg_mode_i;
    logic [NUM_REGIONS-1:0] arm_i;
    logic [IDX_W-1:0]       rd_idx_i;
    logic [CNT_W-1:0]       rd_cycles_o;
    logic [CNT_W-1:0]       rd_retired_o;
    logic [PASS_W-1:0]      rd_passes_o;
    logic [1:0]             rd_state_o;
    logic                   rd_ovf_o;
    logic [NUM_REGIONS-1:0] done_o;
    logic [NUM_REGIONS-1:0] end_evt_o;

    modport master (
        output pc_valid_i, pc_i, retire_i, cfg_we_i, cfg_idx_i, cfg_start_pc_i,
               cfg_end_pc_i, cfg_mode_i, arm_i, rd_idx_i,
        input  rd_cycles_o, rd_retired_o, rd_passes_o, rd_state_o, rd_ovf_o,
               done_o, end_evt_o
    );

    modport slave (
        input  pc_valid_i, pc_i, retire_i, cfg_we_i, cfg_idx_i, cfg_start_pc_i,
               cfg_end_pc_i, cfg_mode_i, arm_i, rd_idx_i,
        output rd_cycles_o, rd_retired_o, rd_passes_o, rd_state_o, rd_ovf_o,
               done_o, end_evt_o
    );
endinterface

// File: rtl/pc_region_profiler.sv
// Multi-region execution profiler: counts cycles and retired instructions between
// a programmable start PC and end PC, one-shot or continuous, per region.
module pc_region_profiler #(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PASS_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pc_region_profiler_if.slave  bus
);
    localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e                 r_state    [NUM_REGIONS];
    logic [PC_W-1:0]        r_start_pc [NUM_REGIONS];
    logic [PC_W-1:0]        r_end_pc   [NUM_REGIONS];
    logic [CNT_W-1:0]       r_cycles   [NUM_REGIONS];
    logic [CNT_W-1:0]       r_retired  [NUM_REGIONS];
    logic [PASS_W-1:0]      r_passes   [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] r_mode;
    logic [NUM_REGIONS-1:0] r_ovf;

    state_e                 w_state    [NUM_REGIONS];
    logic [PC_W-1:0]        w_start_pc [NUM_REGIONS];
    logic [PC_W-1:0]        w_end_pc   [NUM_REGIONS];
    logic [CNT_W-1:0]       w_cycles   [NUM_REGIONS];
    logic [CNT_W-1:0]       w_retired  [NUM_REGIONS];
    logic [PASS_W-1:0]      w_passes   [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] w_mode;
    logic [NUM_REGIONS-1:0] w_ovf;
    logic [NUM_REGIONS-1:0] w_evt;
    logic [NUM_REGIONS-1:0] w_done;

    logic [CNT_W-1:0]       w_rd_cycles;
    logic [CNT_W-1:0]       w_rd_retired;
    logic [PASS_W-1:0]      w_rd_passes;
    logic [1:0]             w_rd_state;
    logic                   w_rd_ovf;

    // Per-region next state: cfg beats arm, arm beats counting, end match only when ACTIVE.
    always_comb begin
        w_state    = r_state;
        w_start_pc = r_start_pc;
        w_end_pc   = r_end_pc;
        w_cycles   = r_cycles;
        w_retired  = r_retired;
        w_passes   = r_passes;
        w_mode     = r_mode;
        w_ovf      = r_ovf;
        w_evt      = '0;
        w_done     = '0;
        for (int k = 0; k < int'(NUM_REGIONS); k++) begin
            if (bus.cfg_we_i && (bus.cfg_idx_i == IDX_W'(k))) begin
                w_start_pc[k] = bus.cfg_start_pc_i;
                w_end_pc[k]   = bus.cfg_end_pc_i;
                w_mode[k]     = bus.cfg_mode_i;
                w_state[k]    = ST_IDLE;
                w_cycles[k]   = '0;
                w_retired[k]  = '0;
                w_passes[k]   = '0;
                w_ovf[k]      = 1'b0;
            end else if (bus.arm_i[k] && (r_state[k] != ST_ARMED)) begin
                w_state[k] = ST_ARMED;
                if (!r_mode[k]) begin
                    w_cycles[k]  = '0;
                    w_retired[k] = '0;
                end
            end else if (r_state[k] == ST_ARMED) begin
                if (bus.pc_valid_i && (bus.pc_i == r_start_pc[k])) begin
                    w_state[k] = ST_ACTIVE;
                end
            end else if (r_state[k] == ST_ACTIVE) begin
                if (&r_cycles[k]) w_ovf[k] = 1'b1;
                else              w_cycles[k] = r_cycles[k] + CNT_W'(1);
                if (bus.retire_i) begin
                    if (&r_retired[k]) w_ovf[k] = 1'b1;
                    else               w_retired[k] = r_retired[k] + CNT_W'(1);
                end
                if (bus.pc_valid_i && (bus.pc_i == r_end_pc[k])) begin
                    w_evt[k] = 1'b1;
                    if (&r_passes[k]) w_ovf[k] = 1'b1;
                    else              w_passes[k] = r_passes[k] + PASS_W'(1);
                    w_state[k] = r_mode[k] ? ST_ARMED : ST_DONE;
                end
            end
            w_done[k] = (w_state[k] == ST_DONE);
        end
    end

    // Read mux over post-edge values; unmatched index reads zero.
    always_comb begin
        w_rd_cycles  = '0;
        w_rd_retired = '0;
        w_rd_passes  = '0;
        w_rd_state   = '0;
        w_rd_ovf     = 1'b0;
        for (int k = 0; k < int'(NUM_REGIONS); k++) begin
            if (bus.rd_idx_i == IDX_W'(k)) begin
                w_rd_cycles  = w_cycles[k];
                w_rd_retired = w_retired[k];
                w_rd_passes  = w_passes[k];
                w_rd_state   = w_state[k];
                w_rd_ovf     = w_ovf[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= '{default: ST_IDLE};
            r_start_pc      <= '{default: '0};
            r_end_pc        <= '{default: '0};
            r_cycles        <= '{default: '0};
            r_retired       <= '{default: '0};
            r_passes        <= '{default: '0};
            r_mode          <= '0;
            r_ovf           <= '0;
            bus.rd_cycles_o  <= '0;
            bus.rd_retired_o <= '0;
            bus.rd_passes_o  <= '0;
            bus.rd_state_o   <= '0;
            bus.rd_ovf_o     <= 1'b0;
            bus.done_o       <= '0;
            bus.end_evt_o    <= '0;
        end else begin
            r_state         <= w_state;
            r_start_pc      <= w_start_pc;
            r_end_pc        <= w_end_pc;
            r_cycles        <= w_cycles;
            r_retired       <= w_retired;
            r_passes        <= w_passes;
            r_mode          <= w_mode;
            r_ovf           <= w_ovf;
            bus.rd_cycles_o  <= w_rd_cycles;
            bus.rd_retired_o <= w_rd_retired;
            bus.rd_passes_o  <= w_rd_passes;
            bus.rd_state_o   <= w_rd_state;
            bus.rd_ovf_o     <= w_rd_ovf;
            bus.done_o       <= w_done;
            bus.end_evt_o    <= w_evt;
        end
    end
endmodule

// File: tb/tb_pc_region_profiler.sv
// Self-checking bench for pc_region_profiler: directed scenarios plus random traffic
// against a behavioural per-region model.
module tb_pc_region_profiler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_region_profiler_if #(.NUM_REGIONS(4), .PC_W(32), .CNT_W(32), .PASS_W(16)) bus ();
    pc_region_profiler_if #(.NUM_REGIONS(3), .PC_W(32), .CNT_W(4), .PASS_W(16)) bus_s ();

    pc_region_profiler #(.NUM_REGIONS(4), .PC_W(32), .CNT_W(32), .PASS_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus));
    pc_region_profiler #(.NUM_REGIONS(3), .PC_W(32), .CNT_W(4), .PASS_W(16)) dut_s (
        .clk_i(clk), .rst_i(rst), .bus(bus_s));

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the 4-region instance; states 0 IDLE, 1 ARMED, 2 ACTIVE, 3 DONE.
    localparam longint CMAX = 64'hFFFF_FFFF;
    localparam longint PMAX = 64'hFFFF;
    int          m_st   [4];
    logic [31:0] m_sp   [4];
    logic [31:0] m_ep   [4];
    bit          m_mode [4];
    longint      m_cyc  [4];
    longint      m_ret  [4];
    longint      m_pass [4];
    bit          m_ovf  [4];
    bit   [3:0]  m_evt;

    function void model_step();
        m_evt = '0;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_st[k] = 0; m_sp[k] = '0; m_ep[k] = '0; m_mode[k] = 0;
                m_cyc[k] = 0; m_ret[k] = 0; m_pass[k] = 0; m_ovf[k] = 0;
            end else if (bus.cfg_we_i && int'(bus.cfg_idx_i) == k) begin
                m_sp[k] = bus.cfg_start_pc_i; m_ep[k] = bus.cfg_end_pc_i; m_mode[k] = bus.cfg_mode_i;
                m_st[k] = 0; m_cyc[k] = 0; m_ret[k] = 0; m_pass[k] = 0; m_ovf[k] = 0;
            end else if (bus.arm_i[k] && m_st[k] != 1) begin
                m_st[k] = 1;
                if (!m_mode[k]) begin m_cyc[k] = 0; m_ret[k] = 0; end
            end else if (m_st[k] == 1) begin
                if (bus.pc_valid_i && bus.pc_i == m_sp[k]) m_st[k] = 2;
            end else if (m_st[k] == 2) begin
                if (m_cyc[k] == CMAX) m_ovf[k] = 1; else m_cyc[k]++;
                if (bus.retire_i) begin
                    if (m_ret[k] == CMAX) m_ovf[k] = 1; else m_ret[k]++;
                end
                if (bus.pc_valid_i && bus.pc_i == m_ep[k]) begin
                    m_evt[k] = 1'b1;
                    if (m_pass[k] == PMAX) m_ovf[k] = 1; else m_pass[k]++;
                    m_st[k] = m_mode[k] ? 1 : 3;
                end
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.pc_valid_i = 0; bus.pc_i = '0; bus.retire_i = 0; bus.cfg_we_i = 0;
        bus.cfg_idx_i = '0; bus.cfg_start_pc_i = '0; bus.cfg_end_pc_i = '0;
        bus.cfg_mode_i = 0; bus.arm_i = '0;
    endtask

    task automatic idle_s();
        bus_s.pc_valid_i = 0; bus_s.pc_i = '0; bus_s.retire_i = 0; bus_s.cfg_we_i = 0;
        bus_s.cfg_idx_i = '0; bus_s.cfg_start_pc_i = '0; bus_s.cfg_end_pc_i = '0;
        bus_s.cfg_mode_i = 0; bus_s.arm_i = '0;
    endtask

    task automatic do_cfg(input logic [1:0] k, input logic [31:0] sp, input logic [31:0] ep, input logic md);
        idle();
        bus.cfg_we_i = 1; bus.cfg_idx_i = k; bus.cfg_start_pc_i = sp;
        bus.cfg_end_pc_i = ep; bus.cfg_mode_i = md;
        cycle();
        idle();
    endtask

    task automatic do_arm(input int k);
        idle();
        bus.arm_i = 4'(1 << k);
        cycle();
        idle();
    endtask

    task automatic do_pc(input logic [31:0] pc, input logic ret);
        bus.pc_valid_i = 1; bus.pc_i = pc; bus.retire_i = ret;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        rst = 1; idle(); idle_s(); bus.rd_idx_i = '0; bus_s.rd_idx_i = '0;
        repeat (3) cycle();
        n_vec++; if (bus.rd_cycles_o !== 32'd0) begin n_err++; $display("FAIL reset_cycles got %0h exp 0", bus.rd_cycles_o); end
        n_vec++; if (bus.rd_retired_o !== 32'd0) begin n_err++; $display("FAIL reset_retired got %0h exp 0", bus.rd_retired_o); end
        n_vec++; if (bus.rd_passes_o !== 16'd0) begin n_err++; $display("FAIL reset_passes got %0h exp 0", bus.rd_passes_o); end
        n_vec++; if (bus.rd_state_o !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", bus.rd_state_o); end
        n_vec++; if ({bus.rd_ovf_o, bus.done_o, bus.end_evt_o} !== 9'd0) begin n_err++; $display("FAIL reset_flags got %0h exp 0", {bus.rd_ovf_o, bus.done_o, bus.end_evt_o}); end
        n_vec++; if ({bus_s.rd_cycles_o, bus_s.rd_state_o, bus_s.rd_ovf_o, bus_s.done_o} !== 10'd0) begin n_err++; $display("FAIL reset_sat_inst got %0h exp 0", {bus_s.rd_cycles_o, bus_s.rd_state_o, bus_s.rd_ovf_o, bus_s.done_o}); end
        rst = 0;
    endtask

    task automatic test_oneshot();
        logic [9:0] pat;
        int pulses;
        pat = 10'b1011010110;
        pulses = 0;
        bus.rd_idx_i = 2'd0;
        do_cfg(2'd0, 32'h170, 32'h264, 1'b0);
        do_arm(0);
        do_pc(32'h16c, 1'b0);
        n_vec++; if (bus.rd_state_o !== 2'd1) begin n_err++; $display("FAIL oneshot_armed got %0d exp 1", bus.rd_state_o); end
        do_pc(32'h170, 1'b1);
        n_vec++; if ({bus.rd_state_o, bus.rd_cycles_o, bus.rd_retired_o} !== {2'd2, 32'd0, 32'd0}) begin n_err++; $display("FAIL oneshot_start got st=%0d cyc=%0d ret=%0d exp 2/0/0", bus.rd_state_o, bus.rd_cycles_o, bus.rd_retired_o); end
        for (int i = 0; i < 10; i++) begin
            do_pc(32'h174 + 32'(i) * 32'd4, pat[i]);
            pulses += int'(bus.end_evt_o[0]);
        end
        do_pc(32'h264, 1'b1);
        pulses += int'(bus.end_evt_o[0]);
        n_vec++; if (bus.rd_cycles_o !== 32'd11) begin n_err++; $display("FAIL oneshot_cycles got %0d exp 11", bus.rd_cycles_o); end
        n_vec++; if (bus.rd_retired_o !== 32'd7) begin n_err++; $display("FAIL oneshot_retired got %0d exp 7", bus.rd_retired_o); end
        n_vec++; if ({bus.rd_passes_o, bus.rd_state_o, bus.done_o[0]} !== {16'd1, 2'd3, 1'b1}) begin n_err++; $display("FAIL oneshot_done got pass=%0d st=%0d done=%0b exp 1/3/1", bus.rd_passes_o, bus.rd_state_o, bus.done_o[0]); end
        cycle();
        pulses += int'(bus.end_evt_o[0]);
        n_vec++; if (pulses !== 1 || bus.done_o[0] !== 1'b1) begin n_err++; $display("FAIL oneshot_pulse got pulses=%0d done=%0b exp 1/1", pulses, bus.done_o[0]); end
    endtask

    task automatic test_continuous();
        bit done_seen;
        done_seen = 0;
        bus.rd_idx_i = 2'd1;
        do_cfg(2'd1, 32'h100, 32'h120, 1'b1);
        do_arm(1);
        for (int p = 0; p < 3; p++) begin
            do_pc(32'h100, 1'b1); done_seen |= bus.done_o[1];
            for (int j = 0; j < 3; j++) begin
                do_pc(32'h104 + 32'(j) * 32'd4, 1'b1); done_seen |= bus.done_o[1];
            end
            do_pc(32'h120, 1'b1); done_seen |= bus.done_o[1];
            n_vec++; if ({bus.rd_state_o, bus.end_evt_o[1]} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL cont_pass%0d got st=%0d evt=%0b exp 1/1", p, bus.rd_state_o, bus.end_evt_o[1]); end
        end
        n_vec++; if ({bus.rd_cycles_o, bus.rd_retired_o, bus.rd_passes_o} !== {32'd12, 32'd12, 16'd3}) begin n_err++; $display("FAIL cont_counts got %0d/%0d/%0d exp 12/12/3", bus.rd_cycles_o, bus.rd_retired_o, bus.rd_passes_o); end
        n_vec++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL cont_done got %0b exp 0", done_seen); end
    endtask

    task automatic test_precedence();
        bus.rd_idx_i = 2'd2;
        idle();
        bus.cfg_we_i = 1; bus.cfg_idx_i = 2'd2; bus.cfg_start_pc_i = 32'h300;
        bus.cfg_end_pc_i = 32'h400; bus.cfg_mode_i = 0; bus.arm_i = 4'b0100;
        cycle();
        idle();
        n_vec++; if (bus.rd_state_o !== 2'd0) begin n_err++; $display("FAIL prec_cfg_arm got %0d exp 0", bus.rd_state_o); end
        do_arm(2);
        do_pc(32'h300, 1'b0);
        do_pc(32'h304, 1'b1);
        do_pc(32'h308, 1'b1);
        n_vec++; if ({bus.rd_state_o, bus.rd_cycles_o} !== {2'd2, 32'd2}) begin n_err++; $display("FAIL prec_active got st=%0d cyc=%0d exp 2/2", bus.rd_state_o, bus.rd_cycles_o); end
        do_arm(2);
        n_vec++; if ({bus.rd_state_o, bus.rd_cycles_o, bus.rd_retired_o} !== {2'd1, 32'd0, 32'd0}) begin n_err++; $display("FAIL prec_rearm got st=%0d cyc=%0d ret=%0d exp 1/0/0", bus.rd_state_o, bus.rd_cycles_o, bus.rd_retired_o); end
    endtask

    task automatic test_equal();
        bus.rd_idx_i = 2'd3;
        do_cfg(2'd3, 32'h200, 32'h200, 1'b0);
        do_arm(3);
        do_pc(32'h200, 1'b0);
        n_vec++; if ({bus.rd_state_o, bus.rd_cycles_o, bus.end_evt_o[3]} !== {2'd2, 32'd0, 1'b0}) begin n_err++; $display("FAIL equal_start got st=%0d cyc=%0d evt=%0b exp 2/0/0", bus.rd_state_o, bus.rd_cycles_o, bus.end_evt_o[3]); end
        do_pc(32'h204, 1'b0);
        do_pc(32'h200, 1'b0);
        n_vec++; if ({bus.rd_state_o, bus.rd_cycles_o, bus.end_evt_o[3]} !== {2'd3, 32'd2, 1'b1}) begin n_err++; $display("FAIL equal_end got st=%0d cyc=%0d evt=%0b exp 3/2/1", bus.rd_state_o, bus.rd_cycles_o, bus.end_evt_o[3]); end
    endtask

    task automatic test_saturation();
        idle_s();
        bus_s.rd_idx_i = 2'd0;
        bus_s.cfg_we_i = 1; bus_s.cfg_start_pc_i = 32'h10; bus_s.cfg_end_pc_i = 32'hdead_beef;
        cycle();
        idle_s(); bus_s.arm_i = 3'b001;
        cycle();
        idle_s(); bus_s.pc_valid_i = 1; bus_s.pc_i = 32'h10; bus_s.retire_i = 1;
        cycle();
        bus_s.pc_i = 32'h14;
        repeat (20) cycle();
        n_vec++; if ({bus_s.rd_cycles_o, bus_s.rd_retired_o, bus_s.rd_ovf_o, bus_s.rd_state_o} !== {4'hf, 4'hf, 1'b1, 2'd2}) begin n_err++; $display("FAIL sat_counts got cyc=%0d ret=%0d ovf=%0b st=%0d exp 15/15/1/2", bus_s.rd_cycles_o, bus_s.rd_retired_o, bus_s.rd_ovf_o, bus_s.rd_state_o); end
        idle_s(); bus_s.arm_i = 3'b001;
        cycle();
        idle_s();
        n_vec++; if ({bus_s.rd_cycles_o, bus_s.rd_ovf_o, bus_s.rd_state_o} !== {4'h0, 1'b1, 2'd1}) begin n_err++; $display("FAIL sat_ovf_sticky got cyc=%0d ovf=%0b st=%0d exp 0/1/1", bus_s.rd_cycles_o, bus_s.rd_ovf_o, bus_s.rd_state_o); end
        bus_s.rd_idx_i = 2'd3;
        cycle();
        n_vec++; if ({bus_s.rd_cycles_o, bus_s.rd_retired_o, bus_s.rd_passes_o, bus_s.rd_state_o, bus_s.rd_ovf_o} !== 27'd0) begin n_err++; $display("FAIL sat_rd_oob got %0h exp 0", {bus_s.rd_cycles_o, bus_s.rd_retired_o, bus_s.rd_passes_o, bus_s.rd_state_o, bus_s.rd_ovf_o}); end
        bus_s.rd_idx_i = 2'd0; bus_s.cfg_we_i = 1;
        cycle();
        idle_s();
        n_vec++; if ({bus_s.rd_ovf_o, bus_s.rd_state_o} !== {1'b0, 2'd0}) begin n_err++; $display("FAIL sat_cfg_clear got ovf=%0b st=%0d exp 0/0", bus_s.rd_ovf_o, bus_s.rd_state_o); end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] exp_done;
        for (int i = 0; i < 1500; i++) begin
            bus.pc_valid_i     = ($urandom_range(0, 3) != 0);
            bus.pc_i           = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            bus.retire_i       = 1'($urandom_range(0, 1));
            bus.cfg_we_i       = ($urandom_range(0, 30) == 0);
            bus.cfg_idx_i      = 2'($urandom_range(0, 3));
            bus.cfg_start_pc_i = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            bus.cfg_end_pc_i   = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            bus.cfg_mode_i     = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) bus.arm_i[k] = ($urandom_range(0, 11) == 0);
            bus.rd_idx_i       = 2'($urandom_range(0, 3));
            cycle();
            r = int'(bus.rd_idx_i);
            for (int k = 0; k < 4; k++) exp_done[k] = (m_st[k] == 3);
            n_vec++;
            if ({bus.rd_cycles_o, bus.rd_retired_o, bus.rd_passes_o, bus.rd_state_o, bus.rd_ovf_o, bus.done_o, bus.end_evt_o}
                !== {32'(m_cyc[r]), 32'(m_ret[r]), 16'(m_pass[r]), 2'(m_st[r]), m_ovf[r], exp_done, m_evt}) begin
                n_err++;
                $display("FAIL random_%0d idx=%0d got cyc=%0d ret=%0d pass=%0d st=%0d ovf=%0b done=%b evt=%b exp cyc=%0d ret=%0d pass=%0d st=%0d ovf=%0b done=%b evt=%b",
                         i, r, bus.rd_cycles_o, bus.rd_retired_o, bus.rd_passes_o, bus.rd_state_o, bus.rd_ovf_o, bus.done_o, bus.end_evt_o,
                         m_cyc[r], m_ret[r], m_pass[r], m_st[r], m_ovf[r], exp_done, m_evt);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        bus.rd_idx_i = 2'd0;
        do_cfg(2'd0, 32'h500, 32'h5f0, 1'b0);
        do_arm(0);
        do_pc(32'h500, 1'b0);
        do_pc(32'h504, 1'b1);
        n_vec++; if ({bus.rd_state_o, bus.rd_cycles_o} !== {2'd2, 32'd1}) begin n_err++; $display("FAIL arst_pre got st=%0d cyc=%0d exp 2/1", bus.rd_state_o, bus.rd_cycles_o); end
        #3 rst = 1;
        #1;
        n_vec++; if ({bus.rd_cycles_o, bus.rd_retired_o, bus.rd_passes_o, bus.rd_state_o, bus.rd_ovf_o, bus.done_o, bus.end_evt_o} !== 91'd0) begin n_err++; $display("FAIL arst_immediate got %0h exp 0", {bus.rd_cycles_o, bus.rd_retired_o, bus.rd_passes_o, bus.rd_state_o, bus.rd_ovf_o, bus.done_o, bus.end_evt_o}); end
        cycle();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            bus.rd_idx_i = 2'(k);
            cycle();
            n_vec++; if ({bus.rd_state_o, bus.rd_cycles_o, bus.rd_passes_o, bus.done_o} !== 54'd0) begin n_err++; $display("FAIL arst_region%0d got st=%0d cyc=%0d pass=%0d done=%b exp all 0", k, bus.rd_state_o, bus.rd_cycles_o, bus.rd_passes_o, bus.done_o); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        idle_s();
        bus.rd_idx_i = '0;
        bus_s.rd_idx_i = '0;
        test_reset();
        test_oneshot();
        test_continuous();
        test_precedence();
        test_equal();
        test_saturation();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_region_profiler.md
# pc_region_profiler

Synthesizable multi-region execution profiler that sits beside the core's pipeline control. It watches the committed PC and retire strobe, and measures cycles and retired instructions between a programmable start PC and end PC. It supports up to NUM_REGIONS independent regions in one-shot or continuous mode. It replaces the bench-only single-region start/end PC measurement with a hardware block readable through a small register port.

## Interface
- NUM_REGIONS, 4: number of independent profiling regions (1..16).
- PC_W, 32: PC width.
- CNT_W, 32: cycle and retired counter width.
- PASS_W, 16: pass counter width.
- IDX_W, max(1, clog2(NUM_REGIONS)): region index width (derived).
- clk_i  in  1  core clock; one clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- pc_valid_i  in  1  pc_i is valid this cycle.
- pc_i  in  PC_W  current PC from the pipeline HPC request.
- retire_i  in  1  one instruction retired this cycle.
- cfg_we_i  in  1  configuration write strobe.
- cfg_idx_i  in  IDX_W  region being configured.
- cfg_start_pc_i  in  PC_W  start PC.
- cfg_end_pc_i  in  PC_W  end PC.
- cfg_mode_i  in  1  0 = one-shot, 1 = continuous.
- arm_i  in  NUM_REGIONS  per-region arm pulse.
- rd_idx_i  in  IDX_W  region to read.
- rd_cycles_o  out  CNT_W  cycle count of region rd_idx_i (registered).
- rd_retired_o  out  CNT_W  retired count (registered).
- rd_passes_o  out  PASS_W  completed passes (registered).
- rd_state_o  out  2  region state: 0 IDLE, 1 ARMED, 2 ACTIVE, 3 DONE (registered).
- rd_ovf_o  out  1  sticky saturation flag of the region (registered).
- done_o  out  NUM_REGIONS  level; bit k is 1 while region k is in DONE.
- end_evt_o  out  NUM_REGIONS  one-cycle pulse when region k matches its end PC.

## Operation
- Each region has its own state, start_pc, end_pc, mode, cycles, retired, passes and ovf.
- All reset to 0 / IDLE.
- cfg_we_i for region k:
  - loads start_pc, end_pc and mode;
  - forces IDLE;
  - clears cycles, retired, passes and ovf.
- Configuration wins over arm_i[k] in the same cycle; the arm is dropped.
- arm_i[k] in IDLE, DONE or ACTIVE moves region k to ARMED.
- On arm, one-shot mode clears cycles and retired. Continuous mode keeps them and always keeps passes.
- arm_i[k] in ARMED has no effect.
- ARMED, with pc_valid_i and pc_i == start_pc:
  - region goes to ACTIVE;
  - the match cycle itself counts nothing.
- While ACTIVE, every cycle (including the end-match cycle):
  - cycles += 1;
  - retired += 1 when retire_i is high.
- ACTIVE, with pc_valid_i and pc_i == end_pc:
  - end_evt_o[k] pulses;
  - passes += 1;
  - one-shot mode goes to DONE; continuous mode goes back to ARMED.
- The end PC is compared only in ACTIVE. If start_pc == end_pc, the region ends on the next occurrence of that PC, never on the start cycle.
- All counters saturate at all-ones. Any increment attempted at all-ones sets ovf, which stays set until the next cfg write.
- The read port registers the mux of region rd_idx_i.
- rd_idx_i >= NUM_REGIONS reads all zeros.

## Timing
- All state, counters and outputs are reset asynchronously on rst_i. Every output is 0 during and after reset.
- Counters and state update on the clk_i edge that samples the qualifying inputs.
- done_o and end_evt_o are registered: they are visible in the cycle after the end-match edge.
- end_evt_o is high for exactly one cycle per pass.
- Read latency is 1 cycle: rd_* reflects the region state after the edge where rd_idx_i was sampled.
- Reset asserted mid-measurement aborts every region to IDLE with zeroed counters. There is no partial retention.
- Regions are fully independent. Several regions may start or end on the same cycle and the same PC.

## Test plan
- One-shot basic:
  - stimulus: cfg region 0, start 0x170, end 0x264, arm; PC sequence 0x16c, 0x170, then 10 cycles with 6 retires, then 0x264 with retire.
  - response: cycles=11, retired=7, passes=1, state=DONE, done_o[0]=1, end_evt_o[0] a single pulse.
- Continuous accumulate:
  - stimulus: region 1, mode 1, start 0x100, end 0x120; three passes of 4 cycles each with 1 retire per cycle.
  - response: cycles=12, retired=12, passes=3, state returns to ARMED after each pass, done_o[1] never set.
- Precedence:
  - stimulus: cfg write and arm_i[2] in the same cycle.
  - response: region 2 is IDLE.
  - stimulus: arm while ACTIVE in one-shot mode.
  - response: region is ARMED with counters 0.
- Equal start/end:
  - stimulus: start = end = 0x200; PC 0x200, 0x204, 0x200.
  - response: ACTIVE after the first 0x200, DONE after the second; cycles=2.
- Saturation:
  - stimulus: CNT_W=4; run 20 ACTIVE cycles.
  - response: cycles=15, ovf=1, ovf cleared only by a cfg write.
- Async reset:
  - stimulus: assert rst_i mid-ACTIVE, between clock edges.
  - response: all rd_* outputs, done_o and end_evt_o go to 0 immediately; state is IDLE.
